spike_rate_meter: RTL and testbench

//  Downstream consumer of the oscillator network's spike_output. Synchronises the spike line,

---
 rtl/osc_net_pkg.sv | 18 +
 rtl/spike_sync_edge.sv | 33 +++
 rtl/spike_rate_meter.sv | 131 +++++++++++++
 tb/tb_spike_rate_meter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/osc_net_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : osc_net_pkg
//  Description : Shared types and default widths for oscillator-network stages.
//  Revision    : 1.0 - initial release
// ============================================================================
package osc_net_pkg;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_GATE = 1'b1
    } meter_state_t;

    localparam int c_default_cnt_w = 8;
    localparam int c_default_isi_w = 16;

endpackage : osc_net_pkg
`default_nettype wire

// File: rtl/spike_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : spike_sync_edge
//  Description : Two-flop synchroniser plus delay flop; emits a one-cycle rise pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module spike_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic spike_in,
    output logic rise
);

    logic r_sync1;
    logic r_sync2;
    logic r_dly;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_dly   <= 1'b0;
        end else begin
            r_sync1 <= spike_in;
            r_sync2 <= r_sync1;
            r_dly   <= r_sync2;
        end
    end

    assign rise = r_sync2 & ~r_dly;

endmodule : spike_sync_edge
`default_nettype wire

// File: rtl/spike_rate_meter.sv
`default_nettype none
// ============================================================================
//  Module      : spike_rate_meter
//  Description : Counts spikes per gate window and measures inter-spike interval,
//                with valid/ack result handshake and sticky overrun flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module spike_rate_meter
    import osc_net_pkg::*;
#(
    parameter int GATE_CYCLES = 1000,
    parameter int CNT_W       = c_default_cnt_w,
    parameter int ISI_W       = c_default_isi_w
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             spike_in,
    input  logic             result_ack,
    output logic [CNT_W-1:0] rate_count,
    output logic             rate_sat,
    output logic             result_valid,
    output logic             overrun,
    output logic [ISI_W-1:0] isi_cycles,
    output logic             isi_valid
);

    localparam int                    c_gate_w    = $clog2(GATE_CYCLES);
    localparam logic [c_gate_w-1:0]   c_gate_last = c_gate_w'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]      c_cnt_max   = '1;
    localparam logic [ISI_W-1:0]      c_isi_max   = '1;

    meter_state_t        r_state;
    logic [c_gate_w-1:0] r_gate_cnt;
    logic [CNT_W-1:0]    r_spike_cnt;
    logic                r_sat;
    logic                r_have_prev;
    logic [ISI_W-1:0]    r_isi_timer;

    logic                w_rise;
    logic                w_cnt_full;
    logic [CNT_W-1:0]    w_cnt_next;
    logic                w_sat_next;
    logic                w_win_done;

    spike_sync_edge u_sync_edge (
        .clk      (clk),
        .reset    (reset),
        .spike_in (spike_in),
        .rise     (w_rise)
    );

    // Count including the rise of the current cycle, so the closing cycle is not lost.
    assign w_cnt_full = (r_spike_cnt == c_cnt_max);
    assign w_cnt_next = w_cnt_full ? r_spike_cnt : r_spike_cnt + CNT_W'(w_rise);
    assign w_sat_next = r_sat | (w_rise & w_cnt_full);
    assign w_win_done = (r_state == S_GATE) && enable && (r_gate_cnt == c_gate_last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_gate_cnt   <= '0;
            r_spike_cnt  <= '0;
            r_sat        <= 1'b0;
            r_have_prev  <= 1'b0;
            r_isi_timer  <= '0;
            rate_count   <= '0;
            rate_sat     <= 1'b0;
            result_valid <= 1'b0;
            overrun      <= 1'b0;
            isi_cycles   <= '0;
            isi_valid    <= 1'b0;
        end else begin
            isi_valid <= 1'b0;

            if (w_win_done) begin
                rate_count   <= w_cnt_next;
                rate_sat     <= w_sat_next;
                result_valid <= 1'b1;
            end else if (result_ack) begin
                result_valid <= 1'b0;
            end
            overrun <= (w_win_done & result_valid & ~result_ack) | (overrun & ~result_ack);

            case (r_state)
                S_IDLE: begin
                    r_gate_cnt  <= '0;
                    r_spike_cnt <= '0;
                    r_sat       <= 1'b0;
                    r_have_prev <= 1'b0;
                    r_isi_timer <= '0;
                    if (enable) r_state <= S_GATE;
                end
                S_GATE: begin
                    if (!enable) begin
                        r_state     <= S_IDLE;
                        r_gate_cnt  <= '0;
                        r_spike_cnt <= '0;
                        r_sat       <= 1'b0;
                        r_have_prev <= 1'b0;
                        r_isi_timer <= '0;
                    end else begin
                        if (w_win_done) begin
                            r_gate_cnt  <= '0;
                            r_spike_cnt <= '0;
                            r_sat       <= 1'b0;
                        end else begin
                            r_gate_cnt  <= r_gate_cnt + c_gate_w'(1);
                            r_spike_cnt <= w_cnt_next;
                            r_sat       <= w_sat_next;
                        end

                        if (w_rise) begin
                            if (r_have_prev) begin
                                isi_cycles <= r_isi_timer;
                                isi_valid  <= 1'b1;
                            end
                            r_isi_timer <= ISI_W'(1);
                            r_have_prev <= 1'b1;
                        end else if (r_isi_timer != c_isi_max) begin
                            r_isi_timer <= r_isi_timer + ISI_W'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule : spike_rate_meter
`default_nettype wire

// File: tb/tb_spike_rate_meter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spike_rate_meter
//  Description : Directed self-checking bench; a second instance uses narrow widths.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spike_rate_meter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        spike_in = 1'b0;
    logic        result_ack = 1'b0;

    logic [7:0]  rate_count;
    logic        rate_sat, result_valid, overrun, isi_valid;
    logic [15:0] isi_cycles;
    logic [2:0]  s_rate_count;
    logic        s_rate_sat, s_result_valid, s_overrun, s_isi_valid;
    logic [3:0]  s_isi_cycles;

    int checks = 0;
    int errors = 0;
    int isi_pulses = 0;
    int pulse_base = 0;

    always #5 clk = ~clk;

    spike_rate_meter #(.GATE_CYCLES(100), .CNT_W(8), .ISI_W(16)) dut (
        .clk(clk), .reset(reset), .enable(enable), .spike_in(spike_in),
        .result_ack(result_ack), .rate_count(rate_count), .rate_sat(rate_sat),
        .result_valid(result_valid), .overrun(overrun),
        .isi_cycles(isi_cycles), .isi_valid(isi_valid)
    );

    spike_rate_meter #(.GATE_CYCLES(100), .CNT_W(3), .ISI_W(4)) dut_small (
        .clk(clk), .reset(reset), .enable(enable), .spike_in(spike_in),
        .result_ack(result_ack), .rate_count(s_rate_count), .rate_sat(s_rate_sat),
        .result_valid(s_result_valid), .overrun(s_overrun),
        .isi_cycles(s_isi_cycles), .isi_valid(s_isi_valid)
    );

    always @(negedge clk) if (isi_valid) isi_pulses++;

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Leaves the bench just after the edge that enters GATE (gate_cnt = 0).
    task automatic start_gate();
        reset = 1'b1; enable = 1'b0; spike_in = 1'b0; result_ack = 1'b0;
        cycles(2);
        reset = 1'b0; enable = 1'b1;
        cycles(1);
        pulse_base = isi_pulses;
    endtask

    task automatic pulse(input int n);
        for (int i = 0; i < n; i++) begin
            spike_in = 1'b1; cycles(2);
            spike_in = 1'b0; cycles(3);
        end
    endtask

    task automatic test_reset();
        start_gate();
        pulse(3);
        checks++; if (isi_cycles !== 16'd5) begin errors++; $display("FAIL reset_pre_isi got %0d exp 5", isi_cycles); end
        cycles(5);
        reset = 1'b1;
        #2;
        checks++;
        if ({rate_count, rate_sat, result_valid, overrun, isi_cycles, isi_valid} !== 29'd0) begin
            errors++; $display("FAIL reset_async_clear got %h exp 0",
                {rate_count, rate_sat, result_valid, overrun, isi_cycles, isi_valid});
        end
        cycles(3);
        checks++;
        if ({rate_count, rate_sat, result_valid, overrun, isi_cycles, isi_valid} !== 29'd0) begin
            errors++; $display("FAIL reset_held got %h exp 0",
                {rate_count, rate_sat, result_valid, overrun, isi_cycles, isi_valid});
        end
        reset = 1'b0;
        cycles(77);
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_no_partial got %0b exp 0", result_valid); end
        cycles(24);
        checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL reset_new_window_valid got %0b exp 1", result_valid); end
        checks++; if (rate_count !== 8'd0) begin errors++; $display("FAIL reset_new_window_count got %0d exp 0", rate_count); end
    endtask

    task automatic test_rate_isi();
        start_gate();
        for (int i = 0; i < 5; i++) begin
            spike_in = 1'b1; cycles(4);
            spike_in = 1'b0; cycles((i == 4) ? 15 : 16);
        end
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL rate_early_valid got %0b exp 0", result_valid); end
        cycles(1);
        checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL rate_valid got %0b exp 1", result_valid); end
        checks++; if (rate_count !== 8'd5) begin errors++; $display("FAIL rate_count got %0d exp 5", rate_count); end
        checks++; if (rate_sat !== 1'b0) begin errors++; $display("FAIL rate_sat got %0b exp 0", rate_sat); end
        checks++; if (isi_cycles !== 16'd20) begin errors++; $display("FAIL isi_20 got %0d exp 20", isi_cycles); end
        checks++; if (isi_pulses - pulse_base !== 4) begin errors++; $display("FAIL isi_pulses got %0d exp 4", isi_pulses - pulse_base); end
        checks++; if (s_isi_cycles !== 4'd15) begin errors++; $display("FAIL isi_small_sat got %0d exp 15", s_isi_cycles); end
    endtask

    task automatic test_saturation();
        start_gate();
        for (int i = 0; i < 10; i++) begin
            spike_in = 1'b1; cycles(3);
            spike_in = 1'b0; cycles(7);
        end
        checks++; if (rate_count !== 8'd10) begin errors++; $display("FAIL sat_wide_count got %0d exp 10", rate_count); end
        checks++; if (rate_sat !== 1'b0) begin errors++; $display("FAIL sat_wide_flag got %0b exp 0", rate_sat); end
        checks++; if (s_rate_count !== 3'd7) begin errors++; $display("FAIL sat_small_count got %0d exp 7", s_rate_count); end
        checks++; if (s_rate_sat !== 1'b1) begin errors++; $display("FAIL sat_small_flag got %0b exp 1", s_rate_sat); end
        checks++; if (s_isi_cycles !== 4'd10) begin errors++; $display("FAIL sat_small_isi got %0d exp 10", s_isi_cycles); end
    endtask

    task automatic test_overrun();
        start_gate();
        pulse(2);
        cycles(90);
        checks++; if ({result_valid, overrun, rate_count} !== {1'b1, 1'b0, 8'd2}) begin
            errors++; $display("FAIL ovr_first got v=%0b o=%0b c=%0d exp v=1 o=0 c=2", result_valid, overrun, rate_count); end
        pulse(3);
        cycles(85);
        checks++; if ({result_valid, overrun, rate_count} !== {1'b1, 1'b1, 8'd3}) begin
            errors++; $display("FAIL ovr_second got v=%0b o=%0b c=%0d exp v=1 o=1 c=3", result_valid, overrun, rate_count); end
        result_ack = 1'b1; cycles(1); result_ack = 1'b0;
        checks++; if ({result_valid, overrun} !== 2'b00) begin
            errors++; $display("FAIL ovr_ack got v=%0b o=%0b exp v=0 o=0", result_valid, overrun); end
    endtask

    task automatic test_back_to_back();
        start_gate();
        cycles(100);
        checks++; if ({result_valid, rate_count} !== {1'b1, 8'd0}) begin
            errors++; $display("FAIL b2b_first got v=%0b c=%0d exp v=1 c=0", result_valid, rate_count); end
        pulse(1);
        cycles(94);
        result_ack = 1'b1; cycles(1);
        checks++; if ({result_valid, overrun, rate_count} !== {1'b1, 1'b0, 8'd1}) begin
            errors++; $display("FAIL b2b_ack_on_done got v=%0b o=%0b c=%0d exp v=1 o=0 c=1", result_valid, overrun, rate_count); end
        cycles(1); result_ack = 1'b0;
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL b2b_ack_clear got %0b exp 0", result_valid); end
    endtask

    task automatic test_enable_drop();
        start_gate();
        pulse(2);
        cycles(40);
        enable = 1'b0;
        cycles(60);
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL en_drop_valid got %0b exp 0", result_valid); end
        checks++; if (isi_cycles !== 16'd5) begin errors++; $display("FAIL en_drop_isi_held got %0d exp 5", isi_cycles); end
        enable = 1'b1;
        cycles(1);
        pulse(1);
        cycles(35);
        pulse(1);
        cycles(55);
        checks++; if ({result_valid, rate_count} !== {1'b1, 8'd2}) begin
            errors++; $display("FAIL en_restart got v=%0b c=%0d exp v=1 c=2", result_valid, rate_count); end
        checks++; if (isi_cycles !== 16'd40) begin errors++; $display("FAIL en_isi_40 got %0d exp 40", isi_cycles); end
        checks++; if (s_isi_cycles !== 4'd15) begin errors++; $display("FAIL en_isi_small_sat got %0d exp 15", s_isi_cycles); end
    endtask

    initial begin
        test_reset();
        test_rate_isi();
        test_saturation();
        test_overrun();
        test_back_to_back();
        test_enable_drop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_spike_rate_meter
`default_nettype wire
